vector_mem_responder: RTL and testbench

- Memory-side responder for the vector pipeline's memory stage. It serves one 8-lane vector load or store per request, backed by a single-port, scalar-wide, synchronous-read SRAM.
- It serialises the vector one lane per cycle and holds `Stall` high until the access completes, so the pipeline freezes its memory stage.
- `RDM` is presented to the memory/writeback buffer in the cycle that `Stall` drops.

---
 rtl/vector_mem_responder_pkg.sv | 19 +
 rtl/scalar_sram.sv | 24 ++
 rtl/vector_mem_responder.sv | 121 ++++++++++++
 tb/tb_vector_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_mem_responder_pkg.sv
// Shared types for the vector memory responder: FSM states, lane count and
// the packed vector type used by the pipeline's memory stage.
package vmem_pkg;

  localparam int LANES_C = 8;
  localparam int N_C     = 20;
  localparam int CNT_W   = $clog2(LANES_C);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } vmem_state_t;

  typedef logic [LANES_C-1:0][N_C-1:0] vec_t;

endpackage

// File: rtl/scalar_sram.sv
// Single-port, scalar-wide SRAM with a registered read port.
// The array has no reset so contents survive a responder reset.
module scalar_sram #(
  parameter int N     = 20,
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vector_mem_responder.sv
// Serialises one 8-lane vector load/store onto a scalar SRAM, one lane per
// cycle, stalling the pipeline until the access completes.
module vector_mem_responder
  import vmem_pkg::*;
#(
  parameter int N      = 20,
  parameter int LANES  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ReqValid,
  input  logic                      MemWriteM,
  input  logic [31:0]               Addr,
  input  logic [LANES-1:0][N-1:0]   WriteData,
  output logic [LANES-1:0][N-1:0]   RDM,
  output logic                      Stall,
  output logic                      Done
);

  localparam int WORD_W = ADDR_W + CNT_W;
  localparam int DEPTH  = (2 ** ADDR_W) * LANES;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  vmem_state_t              state, state_nx;
  logic [CNT_W-1:0]         cnt;
  logic [ADDR_W-1:0]        vidx;
  logic [LANES-1:0][N-1:0]  wdata_hold;

  logic                     sram_we;
  logic [WORD_W-1:0]        sram_addr;
  logic [N-1:0]             sram_wdata;
  logic [N-1:0]             sram_rdata;

  // Upper address bits are deliberately discarded, so vector indices wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:ADDR_W];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == WRITE || state == READ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Holding registers decouple the access from inputs that move while stalled.
  always_ff @(posedge CLK) begin
    if (state == IDLE && ReqValid) begin
      vidx       <= Addr[ADDR_W-1:0];
      wdata_hold <= WriteData;
    end
  end

  // Read data lags the issued address by one edge, hence lane cnt-1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RDM <= '0;
    end else if (state == READ && cnt != '0) begin
      RDM[cnt - 1'b1] <= sram_rdata;
    end else if (state == DRAIN) begin
      RDM[LANES-1] <= sram_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    Stall    = 1'b0;
    Done     = 1'b0;
    sram_we  = 1'b0;
    case (state)
      IDLE: begin
        Stall = ReqValid & RST;
        if (ReqValid) begin
          state_nx = MemWriteM ? WRITE : READ;
        end
      end
      WRITE: begin
        Stall   = 1'b1;
        sram_we = 1'b1;
        if (cnt == LAST_LANE) state_nx = DONE;
      end
      READ: begin
        Stall = 1'b1;
        if (cnt == LAST_LANE) state_nx = DRAIN;
      end
      DRAIN: begin
        Stall    = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        // The finished instruction is still presenting ReqValid here.
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sram_addr  = {vidx, cnt};
  assign sram_wdata = wdata_hold[cnt];

  scalar_sram #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (WORD_W)
  ) u_sram (
    .clk   (CLK),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_vector_mem_responder.sv
// Scoreboard bench for vector_mem_responder: a word-level memory model
// predicts load results, queued at issue and popped when Done pulses.
module tb_vector_mem_responder;
  import vmem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ReqValid;
  logic        MemWriteM;
  logic [31:0] Addr;
  vec_t        WriteData;
  vec_t        RDM;
  logic        Stall;
  logic        Done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N_C-1:0] model [2048];
  vec_t exp_q [$];

  vector_mem_responder #(.N(20), .LANES(8), .ADDR_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ReqValid  (ReqValid),
    .MemWriteM (MemWriteM),
    .Addr      (Addr),
    .WriteData (WriteData),
    .RDM       (RDM),
    .Stall     (Stall),
    .Done      (Done)
  );

  always #5 CLK = ~CLK;

  task automatic model_store(input logic [7:0] v, input vec_t d);
    for (int i = 0; i < 8; i++) model[v*8 + i] = d[i];
  endtask

  function automatic vec_t model_vec(input logic [7:0] v);
    vec_t r;
    for (int i = 0; i < 8; i++) r[i] = model[v*8 + i];
    return r;
  endfunction

  function automatic vec_t fill(input logic [19:0] base, input int step);
    vec_t r;
    for (int i = 0; i < 8; i++) r[i] = base + 20'(i * step);
    return r;
  endfunction

  // Drives one request at cycle T and observes 14 cycles; ReqValid drops
  // after T unless hold is set, in which case it drops after Done.
  task automatic run_access(input bit st, input logic [31:0] a, input vec_t wd,
                            input bit hold, input bit scr,
                            output int stall_n, output int done_at,
                            output int done_n, output vec_t rdm_done);
    @(negedge CLK);
    ReqValid = 1'b1; MemWriteM = st; Addr = a; WriteData = wd;
    stall_n = 0; done_at = -1; done_n = 0; rdm_done = '0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin
        if (!hold || done_at >= 0) ReqValid = 1'b0;
        if (scr) begin
          Addr = $urandom;
          for (int i = 0; i < 8; i++) WriteData[i] = 20'($urandom);
        end
      end
      #1;
      if (Stall) stall_n++;
      if (Done) begin
        if (done_at < 0) begin
          done_at  = c;
          rdm_done = RDM;
        end
        done_n++;
      end
      @(negedge CLK);
    end
    ReqValid = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; ReqValid = 1'b1; MemWriteM = 1'b0; Addr = '0; WriteData = '0;
    #2 RST = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (RDM !== '0) begin n_bad++; $display("FAIL reset_rdm got=%h exp=0", RDM); end
    n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    ReqValid = 1'b0;
    @(negedge CLK);
    RST = 1'b1; #1;
    n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall_lo got=%b exp=0", Stall); end
    ReqValid = 1'b1; #1;
    n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL idle_stall_track got=%b exp=1", Stall); end
    ReqValid = 1'b0; #1;
    n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL idle_stall_drop got=%b exp=0", Stall); end
  endtask

  task automatic test_store_load;
    int sn, da, dn; vec_t r, e;
    model_store(8'd3, fill(20'h00100, 1));
    run_access(1'b1, 32'd3, fill(20'h00100, 1), 1'b0, 1'b0, sn, da, dn, r);
    n_cmp++; if (sn !== 9) begin n_bad++; $display("FAIL store_stall_cycles got=%0d exp=9", sn); end
    n_cmp++; if (da !== 9) begin n_bad++; $display("FAIL store_done_at got=%0d exp=9", da); end
    n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL store_done_count got=%0d exp=1", dn); end
    exp_q.push_back(model_vec(8'd3));
    run_access(1'b0, 32'd3, '0, 1'b0, 1'b0, sn, da, dn, r);
    n_cmp++; if (sn !== 10) begin n_bad++; $display("FAIL load_stall_cycles got=%0d exp=10", sn); end
    n_cmp++; if (da !== 10) begin n_bad++; $display("FAIL load_done_at got=%0d exp=10", da); end
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL load_rdm got=%h exp=%h", r, e); end
    #1;
    n_cmp++; if (RDM !== e) begin n_bad++; $display("FAIL rdm_hold got=%h exp=%h", RDM, e); end
  endtask

  task automatic test_alias;
    int sn, da, dn; vec_t r, e;
    exp_q.push_back(model_vec(8'd3));
    run_access(1'b0, 32'h103, '0, 1'b0, 1'b0, sn, da, dn, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL alias_103 got=%h exp=%h", r, e); end
    model_store(8'd0, fill(20'h00040, 3));
    run_access(1'b1, 32'd0, fill(20'h00040, 3), 1'b0, 1'b0, sn, da, dn, r);
    model_store(8'd255, fill(20'hFFFFF, 0));
    run_access(1'b1, 32'd255, fill(20'hFFFFF, 0), 1'b0, 1'b0, sn, da, dn, r);
    n_cmp++; if (RDM !== e) begin n_bad++; $display("FAIL rdm_through_store got=%h exp=%h", RDM, e); end
    exp_q.push_back(model_vec(8'd255));
    run_access(1'b0, 32'd255, '0, 1'b0, 1'b0, sn, da, dn, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL top_vector got=%h exp=%h", r, e); end
    exp_q.push_back(model_vec(8'd0));
    run_access(1'b0, 32'h100, '0, 1'b0, 1'b0, sn, da, dn, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL vector0_untouched got=%h exp=%h", r, e); end
  endtask

  task automatic test_back_to_back;
    int dcnt, seen, da; vec_t r, e;
    model_store(8'd10, fill(20'h00300, 1));
    @(negedge CLK);
    ReqValid = 1'b1; MemWriteM = 1'b1; Addr = 32'd10; WriteData = fill(20'h00300, 1);
    dcnt = 0; seen = -1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (Done) begin dcnt++; seen = c; end
      @(negedge CLK);
    end
    #1;
    if (Done) dcnt++;
    n_cmp++; if (dcnt !== 1) begin n_bad++; $display("FAIL b2b_done_once got=%0d exp=1", dcnt); end
    n_cmp++; if (seen !== 9) begin n_bad++; $display("FAIL b2b_done_at got=%0d exp=9", seen); end
    MemWriteM = 1'b0;
    exp_q.push_back(model_vec(8'd10));
    #1;
    n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL b2b_restall got=%b exp=1", Stall); end
    da = -1; r = '0;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) ReqValid = 1'b0;
      if (c > 0) #1;
      if (Done && da < 0) begin da = c; r = RDM; end
      @(negedge CLK);
    end
    n_cmp++; if (da !== 10) begin n_bad++; $display("FAIL b2b_load_done_at got=%0d exp=10", da); end
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL b2b_load_rdm got=%h exp=%h", r, e); end
  endtask

  task automatic test_reset_mid_store;
    int sn, da, dn; vec_t r, e, nv;
    model_store(8'd5, fill(20'h0AAAA, 0));
    run_access(1'b1, 32'd5, fill(20'h0AAAA, 0), 1'b0, 1'b0, sn, da, dn, r);
    nv = fill(20'h15555, 0);
    @(negedge CLK);
    ReqValid = 1'b1; MemWriteM = 1'b1; Addr = 32'd5; WriteData = nv;
    @(negedge CLK);
    ReqValid = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL midstore_stall got=%b exp=0", Stall); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL midstore_done got=%b exp=0", Done); end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) model[5*8 + i] = nv[i];
    exp_q.push_back(model_vec(8'd5));
    run_access(1'b0, 32'd5, '0, 1'b0, 1'b0, sn, da, dn, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL midstore_partial got=%h exp=%h", r, e); end
  endtask

  task automatic test_input_hold;
    int sn, da, dn; vec_t r, e;
    model_store(8'd9, fill(20'h12340, 7));
    run_access(1'b1, 32'd9, fill(20'h12340, 7), 1'b0, 1'b1, sn, da, dn, r);
    n_cmp++; if (sn !== 9) begin n_bad++; $display("FAIL hold_stall_cycles got=%0d exp=9", sn); end
    exp_q.push_back(model_vec(8'd9));
    run_access(1'b0, 32'd9, '0, 1'b0, 1'b0, sn, da, dn, r);
    e = exp_q.pop_front();
    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL hold_vector got=%h exp=%h", r, e); end
  endtask

  task automatic test_reset_mid_load;
    @(negedge CLK);
    ReqValid = 1'b1; MemWriteM = 1'b0; Addr = 32'd3;
    @(negedge CLK);
    ReqValid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++; if (RDM !== '0) begin n_bad++; $display("FAIL midload_rdm got=%h exp=0", RDM); end
    n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL midload_stall got=%b exp=0", Stall); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL midload_idle got=%b exp=0", Stall); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_back_to_back();
    test_reset_mid_store();
    test_input_hold();
    test_reset_mid_load();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
